mult_hilo_ctrl: RTL
===================

Name: mult_hilo_ctrl

Overview:
- Sequencer and result stage that sits downstream of booth_mult.
- Accepts a MULT request from the control unit and latches the operands that drive the multiplier.
- Waits a fixed number of cycles for the multiplier result to settle, then captures {mostSig, leastSig} into the architectural HI/LO registers.
- Drives busy to stall the CPU and pulses done; also serves MTHI/MTLO writes and MFHI/MFLO reads.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 32, settle cycles granted to booth_mult before capture; legal range 1..255.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  MULT request; sampled only in IDLE.
- op_a  input  WIDTH  multiplicand, latched on accepted start.
- op_b  input  WIDTH  multiplier, latched on accepted start.
- mult_valueA  output  WIDTH  registered multiplicand to booth_mult.
- mult_valueB  output  WIDTH  registered multiplier to booth_mult.
- mult_mostSig  input  WIDTH  upper product word from booth_mult.
- mult_leastSig  input  WIDTH  lower product word from booth_mult.
- hi_write  input  1  MTHI strobe.
- lo_write  input  1  MTLO strobe.
- wr_data  input  WIDTH  MTHI/MTLO data.
- hi  output  WIDTH  HI register (MFHI source).
- lo  output  WIDTH  LO register (MFLO source).
- busy  output  1  high in RUN and CAPTURE; CPU stalls on it.
- done  output  1  one-cycle pulse, high in the cycle new HI/LO are first visible.

Behaviour:
- Reset values: state=IDLE; hi, lo, mult_valueA, mult_valueB, counter = 0; busy=0; done=0.
- Interface rules: all outputs are registered. busy is decoded from state only.
- IDLE:
  - start=1 at an edge: mult_valueA<=op_a, mult_valueB<=op_b, cnt<=0, state<=RUN.
  - Otherwise remain in IDLE.
- RUN:
  - cnt increments each edge.
  - At an edge where cnt==MULT_CYCLES-1: state<=CAPTURE.
  - mult_valueA/B are held constant.
- CAPTURE (exactly one cycle):
  - Next edge: hi<=mult_mostSig, lo<=mult_leastSig, done<=1, state<=IDLE.
- done: cleared on the following edge unless a new capture occurs.
- Latency: start is accepted at edge E. HI/LO update and done rises at edge E+MULT_CYCLES+1 (33 for default). busy is high from E through E+MULT_CYCLES+1 (falls at the same edge done rises).
- start while busy: ignored, with no queueing. The control unit must hold start or re-issue it after done.
- Back-to-back: start may be accepted in the cycle done is high (state is IDLE). The new run begins with no bubble.
- hi_write/lo_write:
  - In IDLE: the addressed register takes wr_data at the edge.
  - Simultaneous with an accepted start: the write still happens; capture later overwrites it.
  - In RUN or CAPTURE: ignored (CPU is stalled; a write is a control bug).
  - hi_write and lo_write may be asserted together.
- hi/lo hold value otherwise. MFHI/MFLO read hi/lo combinationally from the registers with no side effects.
- Reset mid-operation: immediate return to IDLE with the reset values above. No done pulse. The partial product is discarded.
- Counter width: 8 bits. Counter wrap is impossible in legal configurations.
- Product format: {hi, lo} = {mult_mostSig, mult_leastSig}, 2*WIDTH-bit signed two's complement. No interpretation is done here.

Decomposition:
- Shared header mult_defs.vh holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, CAPTURE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - WIDTH and MULT_CYCLES defaults.
- One natural sub-module: mult_cycle_counter.
  - Clear/enable 8-bit counter with terminal-count compare against MULT_CYCLES-1.
  - Instantiated once.
- Everything else is flat in mult_hilo_ctrl.

Test Plan:
- Reset, then start with op_a=3, op_b=5 and a model multiplier returning {0, 15}:
  - busy=1 for 33 cycles.
  - done pulses once at edge E+33.
  - hi=0, lo=15.
- op_a=0xFFFFFFFF (-1), op_b=2, model returns {0xFFFFFFFF, 0xFFFFFFFE}:
  - hi=0xFFFFFFFF, lo=0xFFFFFFFE after capture.
  - mult_valueA/B stable for the whole run.
- Second start during RUN at cycle 10 with different operands:
  - Ignored; only one done.
  - Result from the first operands.
  - mult_valueA unchanged.
- In IDLE, hi_write=1 with wr_data=0xA5A5A5A5 and lo_write=1 with 0x5A5A5A5A:
  - hi/lo updated next edge.
  - The same writes issued during RUN leave hi/lo unchanged.
- Reset asserted at cycle 20 of a run:
  - All outputs 0 asynchronously.
  - No done.
  - A subsequent start completes normally in 33 cycles.
- Start asserted in the same cycle done=1:
  - Accepted; busy stays/returns high with no idle gap.
  - Second done at exactly 33 edges later.

Source files
------------

// File: rtl/mult_hilo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_hilo_ctrl_pkg
// Description : Shared types, defaults and helpers for the MULT sequencer and
//               HI/LO result stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_hilo_ctrl_pkg;

    localparam int c_DEF_WIDTH       = 32;
    localparam int c_DEF_MULT_CYCLES = 32;
    localparam int c_CNT_W           = 8;
    localparam int c_STATE_W         = 2;

    // Encoding 2'd3 is unused; the sequencer treats it as a fault and returns to idle.
    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    function automatic logic state_is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_CAPTURE);
    endfunction

endpackage : mult_hilo_ctrl_pkg
`default_nettype wire

// File: rtl/mult_hilo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_hilo_ctrl_if
// Description : Bundle between the control unit / booth_mult and the HI/LO
//               sequencer. master = control unit side, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_hilo_ctrl_if
    import mult_hilo_ctrl_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] mult_valueA;
    logic [WIDTH-1:0] mult_valueB;
    logic [WIDTH-1:0] mult_mostSig;
    logic [WIDTH-1:0] mult_leastSig;
    logic             hi_write;
    logic             lo_write;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op_a, op_b,
        output mult_mostSig, mult_leastSig,
        output hi_write, lo_write, wr_data,
        input  mult_valueA, mult_valueB,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op_a, op_b,
        input  mult_mostSig, mult_leastSig,
        input  hi_write, lo_write, wr_data,
        output mult_valueA, mult_valueB,
        output hi, lo, busy, done
    );

endinterface : mult_hilo_ctrl_if
`default_nettype wire

// File: rtl/mult_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module      : mult_cycle_counter
// Description : Clear/enable settle counter; terminal flags the last RUN cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_cycle_counter
    import mult_hilo_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = c_DEF_MULT_CYCLES
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic enable,
    output logic      terminal
);

    localparam logic [c_CNT_W-1:0] c_TERMINAL = c_CNT_W'(MULT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign terminal = (r_count == c_TERMINAL);

endmodule : mult_cycle_counter
`default_nettype wire

// File: rtl/mult_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_hilo_ctrl
// Description : MULT sequencer: latches operands for booth_mult, waits the
//               settle time, captures the product into HI/LO, serves MTHI/MTLO.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_hilo_ctrl
    import mult_hilo_ctrl_pkg::*;
#(
    parameter int WIDTH       = c_DEF_WIDTH,
    parameter int MULT_CYCLES = c_DEF_MULT_CYCLES
) (
    input  wire logic         clock,
    input  wire logic         reset,
    mult_hilo_ctrl_if.slave   bus
);

    state_t           r_state;
    logic [WIDTH-1:0] r_value_a;
    logic [WIDTH-1:0] r_value_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_accept;
    logic             w_run;
    logic             w_terminal;

    assign w_accept = (r_state == ST_IDLE) && bus.start;
    assign w_run    = (r_state == ST_RUN);

    mult_cycle_counter #(
        .MULT_CYCLES (MULT_CYCLES)
    ) u_cycle_counter (
        .clock    (clock),
        .reset    (reset),
        .clear    (w_accept),
        .enable   (w_run),
        .terminal (w_terminal)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_value_a <= '0;
            r_value_b <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // MTHI/MTLO land even alongside an accepted start; capture overwrites later.
                    if (bus.hi_write) begin
                        r_hi <= bus.wr_data;
                    end
                    if (bus.lo_write) begin
                        r_lo <= bus.wr_data;
                    end
                    if (bus.start) begin
                        r_value_a <= bus.op_a;
                        r_value_b <= bus.op_b;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_terminal) begin
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_hi    <= bus.mult_mostSig;
                    r_lo    <= bus.mult_leastSig;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mult_valueA = r_value_a;
    assign bus.mult_valueB = r_value_b;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.busy        = state_is_busy(r_state);
    assign bus.done        = r_done;

endmodule : mult_hilo_ctrl
`default_nettype wire
